// File: rtl/xm_store_buffer.sv
// X->M store buffer: muxes store data from forwarding sources, queues stores, drains them to a req/ack memory port.
// Load hits return one cycle after accept; misses wait for any in-flight drain, then read. Optional macro: XM_SB_COALESCE_EN.
module xm_store_buffer #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_W   = 5,
    parameter int DEPTH   = 4,
    parameter int NUM_FWD = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         x_valid,
    input  logic                         x_read,
    input  logic                         x_write,
    input  logic [ADDR_W-1:0]            x_addr,
    input  logic [DATA_W-1:0]            x_val,
    input  logic [REG_W-1:0]             x_dst,
    input  logic [$clog2(NUM_FWD+1)-1:0] fwd_sel,
    input  logic [NUM_FWD*DATA_W-1:0]    fwd_data,
    output logic                         x_ready,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_ack,
    output logic                         ld_valid,
    output logic [DATA_W-1:0]            ld_data,
    output logic [REG_W-1:0]             ld_dst,
    output logic [$clog2(DEPTH+1)-1:0]   sb_count,
    output logic                         sb_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int SEL_W = $clog2(NUM_FWD+1);

    localparam logic [0:0] S_IDLE      = 1'b0;
    localparam logic [0:0] S_LOAD_WAIT = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] sb_addr [DEPTH];
    logic [DATA_W-1:0] sb_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] ld_addr_q;
    logic [REG_W-1:0]  ld_dst_q;

    logic [DATA_W-1:0] store_data;
    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic [PTR_W-1:0]  scan_idx;
    logic              co_hit;
    logic              acc;
    logic              st_acc;
    logic              ld_acc;
    logic              push;
    logic              pop;
    logic              drain_go;
    logic [PTR_W-1:0]  drain_idx;
    logic [DATA_W-1:0] drain_data;

    assign sb_count = cnt;
    assign sb_empty = (cnt == '0);

    // fwd_sel values beyond NUM_FWD fall through to the register-file value
    always_comb begin
        store_data = x_val;
        for (int k = 1; k <= NUM_FWD; k++) begin
            if (fwd_sel == SEL_W'(k))
                store_data = fwd_data[(k-1)*DATA_W +: DATA_W];
        end
    end

    // Scan oldest to youngest so the last match wins
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PTR_W'(i);
            if (CNT_W'(i) < cnt && sb_addr[scan_idx] == x_addr) begin
                hit      = 1'b1;
                hit_data = sb_data[scan_idx];
            end
        end
    end

`ifdef XM_SB_COALESCE_EN
    logic [PTR_W-1:0] co_idx;
    logic [PTR_W-1:0] co_scan;

    // The head is excluded: its fields may already be latched on the memory port
    always_comb begin
        co_hit  = 1'b0;
        co_idx  = '0;
        co_scan = '0;
        for (int i = 1; i < DEPTH; i++) begin
            co_scan = head + PTR_W'(i);
            if (CNT_W'(i) < cnt && sb_addr[co_scan] == x_addr) begin
                co_hit = 1'b1;
                co_idx = co_scan;
            end
        end
    end
`else
    assign co_hit = 1'b0;
`endif

    assign x_ready = (state == S_IDLE) && !(x_write && cnt == CNT_W'(DEPTH) && !co_hit);
    assign acc     = x_valid && x_ready;
    assign st_acc  = acc && x_write;
    assign ld_acc  = acc && x_read && !x_write;
    assign push    = st_acc && !co_hit;
    assign pop     = mem_req && mem_we && mem_ack;

    // Back-to-back drain reads the entry behind the one popping this cycle
    assign drain_go  = (state == S_IDLE) && !ld_acc &&
                       ((!mem_req && cnt != '0) || (pop && cnt > CNT_W'(1)));
    assign drain_idx = pop ? head + PTR_W'(1) : head;

`ifdef XM_SB_COALESCE_EN
    assign drain_data = (st_acc && co_hit && co_idx == drain_idx) ? store_data : sb_data[drain_idx];
`else
    assign drain_data = sb_data[drain_idx];
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[tail] <= x_addr;
            sb_data[tail] <= store_data;
        end
`ifdef XM_SB_COALESCE_EN
        else if (st_acc && co_hit) begin
            sb_data[co_idx] <= store_data;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            head      <= '0;
            tail      <= '0;
            cnt       <= '0;
            ld_addr_q <= '0;
            ld_dst_q  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ld_valid  <= 1'b0;
            ld_data   <= '0;
            ld_dst    <= '0;
        end else begin
            ld_valid <= 1'b0;
            if (push)
                tail <= tail + PTR_W'(1);
            if (pop)
                head <= head + PTR_W'(1);
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);

            case (state)
                S_IDLE: begin
                    if (ld_acc) begin
                        if (hit) begin
                            ld_valid <= 1'b1;
                            ld_data  <= hit_data;
                            ld_dst   <= x_dst;
                        end else begin
                            state     <= S_LOAD_WAIT;
                            ld_addr_q <= x_addr;
                            ld_dst_q  <= x_dst;
                        end
                    end
                    if (drain_go) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= sb_addr[drain_idx];
                        mem_wdata <= drain_data;
                    end else if (pop) begin
                        mem_req <= 1'b0;
                    end
                end
                S_LOAD_WAIT: begin
                    if (mem_req && mem_ack && !mem_we) begin
                        mem_req  <= 1'b0;
                        ld_valid <= 1'b1;
                        ld_data  <= mem_rdata;
                        ld_dst   <= ld_dst_q;
                        state    <= S_IDLE;
                    end else if (!mem_req || pop) begin
                        // Read goes out once no drain is in flight (or as it completes)
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= ld_addr_q;
                        mem_wdata <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xm_store_buffer.sv
// Directed bench for xm_store_buffer (DEPTH=4, NUM_FWD=2); coalescing section runs when XM_SB_COALESCE_EN is defined.
module tb_xm_store_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        x_valid, x_read, x_write;
    logic [31:0] x_addr, x_val;
    logic [4:0]  x_dst;
    logic [1:0]  fwd_sel;
    logic [63:0] fwd_data;
    logic        x_ready;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  ld_dst;
    logic [2:0]  sb_count;
    logic        sb_empty;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    xm_store_buffer #(.DATA_W(32), .ADDR_W(32), .REG_W(5), .DEPTH(4), .NUM_FWD(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .x_valid(x_valid), .x_read(x_read), .x_write(x_write),
        .x_addr(x_addr), .x_val(x_val), .x_dst(x_dst),
        .fwd_sel(fwd_sel), .fwd_data(fwd_data), .x_ready(x_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_dst(ld_dst),
        .sb_count(sb_count), .sb_empty(sb_empty)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic v, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [4:0] dst, input logic [1:0] sel);
        x_valid = v; x_read = r; x_write = w;
        x_addr = a; x_val = d; x_dst = dst; fwd_sel = sel;
    endtask

    initial begin
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        op(0, 0, 0, 0, 0, 0, 0);
        fwd_data = {32'h0000ABCD, 32'h00001234};
        tick(); tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_sb_empty", sb_empty, 1);
        chk("rst_ld_valid", ld_valid, 0);
        rst_n = 1'b1;
        tick();
        chk("rel_x_ready", x_ready, 1);

        // forwarding source 1 supplies the store data
        op(1, 0, 1, 32'h40, 32'h11, 0, 2);
        chk("fwd_x_ready", x_ready, 1);
        tick(); op(0, 0, 0, 0, 0, 0, 0);
        chk("fwd_count", sb_count, 1);
        chk("fwd_no_req_yet", mem_req, 0);
        tick();
        chk("fwd_req", mem_req, 1);
        chk("fwd_we", mem_we, 1);
        chk("fwd_addr", mem_addr, 32'h40);
        chk("fwd_wdata", mem_wdata, 32'hABCD);
        tick();
        chk("fwd_hold_wdata", mem_wdata, 32'hABCD);

        // asynchronous reset while the drain is outstanding
        rst_n = 1'b0; #1;
        chk("mrst_req", mem_req, 0);
        chk("mrst_we", mem_we, 0);
        chk("mrst_addr", mem_addr, 0);
        chk("mrst_wdata", mem_wdata, 0);
        chk("mrst_ld", {ld_valid, ld_data, ld_dst}, 0);
        chk("mrst_empty", sb_empty, 1);
        tick(); rst_n = 1'b1; tick();
        chk("mrst_x_ready", x_ready, 1);
        chk("mrst_req_after", mem_req, 0);
        tick(); tick();
        chk("mrst_req_idle", mem_req, 0);

        // fill with drain stalled; also covers fwd_sel 1 and out-of-range 3
        op(1, 0, 1, 32'h100, 32'h1, 0, 0); tick();
        op(1, 0, 1, 32'h104, 32'h99, 0, 1); tick();
        op(1, 0, 1, 32'h108, 32'h3, 0, 3); tick();
        op(1, 0, 1, 32'h10C, 32'h4, 0, 0); tick();
        op(1, 0, 1, 32'h110, 32'h5, 0, 0);
        chk("full_x_ready", x_ready, 0);
        chk("full_count", sb_count, 4);
        chk("full_drain_addr", mem_addr, 32'h100);
        chk("full_drain_wdata", mem_wdata, 32'h1);
        mem_ack = 1'b1;
        chk("full_ready_on_ack", x_ready, 0);
        tick(); mem_ack = 1'b0;
        chk("full_ready_after_pop", x_ready, 1);
        chk("full_count_pop", sb_count, 3);
        chk("full_b2b_addr", mem_addr, 32'h104);
        chk("full_b2b_wdata", mem_wdata, 32'h1234);
        tick(); op(0, 0, 0, 0, 0, 0, 0);
        chk("full_count_refill", sb_count, 4);
        mem_ack = 1'b1;
        tick();
        chk("drain_addr_108", mem_addr, 32'h108);
        chk("drain_wdata_sel3", mem_wdata, 32'h3);
        tick();
        chk("drain_wdata_10c", mem_wdata, 32'h4);
        tick();
        chk("drain_addr_wrap", mem_addr, 32'h110);
        chk("drain_wdata_wrap", mem_wdata, 32'h5);
        tick(); mem_ack = 1'b0;
        chk("drain_done_req", mem_req, 0);
        chk("drain_done_empty", sb_empty, 1);

        // load hit returns youngest matching store
        op(1, 0, 1, 32'h100, 32'h1, 0, 0); tick();
        op(1, 0, 1, 32'h100, 32'h2, 0, 0); tick();
        op(1, 1, 0, 32'h100, 32'h0, 7, 0);
        chk("hit_x_ready", x_ready, 1);
        tick(); op(0, 0, 0, 0, 0, 0, 0);
        chk("hit_ld_valid", ld_valid, 1);
        chk("hit_ld_data", ld_data, 32'h2);
        chk("hit_ld_dst", ld_dst, 7);
        chk("hit_no_read", mem_we, 1);
        chk("hit_drain_wdata", mem_wdata, 32'h1);
        tick();
        chk("hit_pulse_end", ld_valid, 0);

        // load miss while a drain is outstanding
        op(1, 1, 0, 32'h200, 32'h0, 3, 0);
        tick(); op(0, 0, 0, 0, 0, 0, 0);
        chk("miss_x_ready", x_ready, 0);
        chk("miss_drain_first", mem_we, 1);
        mem_ack = 1'b1; mem_rdata = 32'h99;
        tick(); mem_ack = 1'b0;
        chk("miss_rd_req", mem_req, 1);
        chk("miss_rd_we", mem_we, 0);
        chk("miss_rd_addr", mem_addr, 32'h200);
        chk("miss_count", sb_count, 1);
        tick();
        chk("miss_wait_ld", ld_valid, 0);
        mem_ack = 1'b1; mem_rdata = 32'h55;
        tick(); mem_ack = 1'b0;
        chk("miss_ld_valid", ld_valid, 1);
        chk("miss_ld_data", ld_data, 32'h55);
        chk("miss_ld_dst", ld_dst, 3);
        chk("miss_req_drop", mem_req, 0);
        chk("miss_x_ready_back", x_ready, 1);
        tick();
        chk("miss_pulse_end", ld_valid, 0);
        chk("miss_resume_we", mem_we, 1);
        chk("miss_resume_wdata", mem_wdata, 32'h2);
        mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        chk("miss_final_empty", sb_empty, 1);

        // read+write together is a store
        op(1, 1, 1, 32'h300, 32'h77, 9, 0);
        tick(); op(0, 0, 0, 0, 0, 0, 0);
        chk("rw_no_ld", ld_valid, 0);
        chk("rw_count", sb_count, 1);
        tick();
        chk("rw_drain_addr", mem_addr, 32'h300);
        chk("rw_drain_wdata", mem_wdata, 32'h77);
        mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        chk("rw_empty", sb_empty, 1);

        // neither read nor write: consumed, nothing happens; stray ack ignored
        op(1, 0, 0, 32'h400, 32'h88, 4, 0);
        chk("nop_x_ready", x_ready, 1);
        tick(); op(0, 0, 0, 0, 0, 0, 0);
        chk("nop_count", sb_count, 0);
        chk("nop_ld", ld_valid, 0);
        mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        chk("stray_ack_req", mem_req, 0);
        chk("stray_ack_count", sb_count, 0);

`ifdef XM_SB_COALESCE_EN
        op(1, 0, 1, 32'h10, 32'h1, 0, 0); tick();
        op(1, 0, 1, 32'h20, 32'h2, 0, 0); tick();
        op(1, 0, 1, 32'h20, 32'h3, 0, 0); tick();
        op(0, 0, 0, 0, 0, 0, 0);
        chk("co_count", sb_count, 2);
        chk("co_head_wdata", mem_wdata, 32'h1);
        mem_ack = 1'b1;
        tick();
        chk("co_addr", mem_addr, 32'h20);
        chk("co_wdata", mem_wdata, 32'h3);
        tick(); mem_ack = 1'b0;
        chk("co_empty", sb_empty, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
